// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the buffer-fed UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} tx_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clk cycles within one serial bit, pulsing bit_end on the last one
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clear || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/buffer_uart_tx.sv
// buffer_uart_tx: pops bytes from the circular buffer and sends each as an 8N1 UART frame
module buffer_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] bytes_sent
);
  localparam int BW = $clog2(UART_DATA_BITS);
  tx_state_t state;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [BW-1:0] bit_idx;
  logic bit_end;
  // The single-cycle states hold the counter at zero so every serial bit starts from a fresh count
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE || state == POP || state == LOAD),
    .bit_end(bit_end)
  );
  assign busy       = state != IDLE;
  assign fifo_rd_en = state == POP;
  assign frame_done = state == STOP && bit_end;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      shift_reg  <= '0;
      bit_idx    <= '0;
      bytes_sent <= '0;
    end else begin
      case (state)
        IDLE: state <= (tx_enable && !fifo_empty) ? POP : IDLE;
        POP:  state <= LOAD;
        LOAD: begin
          shift_reg <= fifo_rd_data;
          tx        <= 1'b0;
          state     <= START;
        end
        START: if (bit_end) begin
          tx      <= shift_reg[0];
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(UART_DATA_BITS - 1)) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx        <= shift_reg[1];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 1'b1;
          end
        end
        STOP: if (bit_end) begin
          bytes_sent <= bytes_sent + 1'b1;
          state      <= (tx_enable && !fifo_empty) ? POP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buffer_uart_tx.sv
// tb_buffer_uart_tx: random and directed traffic through a buffer model, decoded by a UART line model
module tb_buffer_uart_tx;
  localparam int CPB = 4;
  logic clk = 0, rst = 1, tx_enable = 0, fifo_empty = 1;
  logic [7:0] fifo_rd_data = 0;
  logic fifo_rd_en, tx, busy, frame_done;
  logic [15:0] bytes_sent;
  logic rd_en2, tx2, busy2, done2;
  logic [1:0] bytes_sent2;
  int checks = 0, errors = 0;
  logic [7:0] q[$], popped[$], got[$], cur, rb[5];
  int gaps[$];
  int cyc = 0, pops = 0, frames = 0, exp_cnt = 0, t = 0, start_cyc = 0, end_cyc = -100, c0, p;
  logic in_frame = 0;

  buffer_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frame_done(frame_done), .bytes_sent(bytes_sent)
  );
  buffer_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en2), .tx(tx2), .busy(busy2),
    .frame_done(done2), .bytes_sent(bytes_sent2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got_v, exp_v);
    end
  endtask

  // One clock: buffer model with one-cycle read latency, then a UART line decoder
  task automatic step();
    logic pop, r;
    logic [9:0] f;
    pop = fifo_rd_en;
    r = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (pop) begin
      check("pop_empty", 32'(q.size() == 0), 0);
      fifo_rd_data = q.size() ? q.pop_front() : 8'h00;
      popped.push_back(fifo_rd_data);
      pops++;
    end
    fifo_empty = q.size() == 0;
    check("rd_pulse", 32'(pop & fifo_rd_en), 0);
    if (r) begin
      in_frame = 0;
      exp_cnt = 0;
      popped.delete();
    end
    check("sent", 32'(bytes_sent), 32'(exp_cnt % 65536));
    check("sent2", 32'(bytes_sent2), 32'(exp_cnt % 4));
    check("dut2_tx", 32'(tx2), 32'(tx));
    if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame = 1;
        t = 0;
        check("spur_start", 32'(popped.size() != 0), 1);
        cur = popped.size() ? popped.pop_front() : 8'h00;
        start_cyc = cyc;
        gaps.push_back(cyc - end_cyc);
      end else check("idle_done", 32'(frame_done), 0);
    end
    if (in_frame) begin
      f = {1'b1, cur, 1'b0};
      check("busy", 32'(busy), 1);
      check("tx_bit", 32'(tx), 32'(f[t / CPB]));
      check("fdone", 32'(frame_done), 32'(t == 10 * CPB - 1));
      if (t == 10 * CPB - 1) begin
        in_frame = 0;
        exp_cnt++;
        frames++;
        got.push_back(cur);
        end_cyc = cyc;
      end
      t++;
    end
  endtask

  task automatic wait_frames_to(input int target);
    for (int i = 0; i < 3000 && frames < target; i++) step();
    if (frames < target) check("timeout", 32'(frames), 32'(target));
  endtask

  task automatic wait_bit(input int tt);
    for (int i = 0; i < 300 && !(in_frame && t >= tt); i++) step();
    if (!(in_frame && t >= tt)) check("bit_timeout", 32'(t), 32'(tt));
  endtask

  initial begin
    step();
    step();
    rst = 0;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_cnt", 32'(bytes_sent), 0);
    step();
    // single byte, latency and frame shape
    q.push_back(8'hA5);
    fifo_empty = 0;
    tx_enable = 1;
    c0 = cyc;
    wait_frames_to(1);
    check("latency", 32'(start_cyc - c0), 3);
    repeat (10) step();
    check("t1_pops", 32'(pops), 1);
    check("t1_byte", 32'(got[0]), 32'h A5);
    check("t1_busy", 32'(busy), 0);
    check("t1_cnt", 32'(bytes_sent), 1);
    // back-to-back frames
    gaps.delete();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h3C);
    fifo_empty = 0;
    wait_frames_to(4);
    step();
    check("t2_b0", 32'(got[1]), 32'h00);
    check("t2_b1", 32'(got[2]), 32'hFF);
    check("t2_b2", 32'(got[3]), 32'h3C);
    check("t2_gap1", 32'(gaps[1]), 3);
    check("t2_gap2", 32'(gaps[2]), 3);
    check("t2_pops", 32'(pops), 4);
    check("t2_cnt", 32'(bytes_sent), 4);
    // empty buffer stays idle
    repeat (100) begin
      step();
      check("t3_tx", 32'(tx), 1);
      check("t3_busy", 32'(busy), 0);
      check("t3_rd_en", 32'(fifo_rd_en), 0);
    end
    // disable mid-frame
    q.push_back(8'h55);
    q.push_back(8'h66);
    fifo_empty = 0;
    wait_bit(3 * CPB);
    tx_enable = 0;
    p = pops;
    wait_frames_to(frames + 1);
    repeat (30) begin
      step();
      check("t4_idle_tx", 32'(tx), 1);
    end
    check("t4_pops", 32'(pops), 32'(p));
    check("t4_b0", 32'(got[got.size() - 1]), 32'h55);
    tx_enable = 1;
    wait_frames_to(frames + 1);
    check("t4_b1", 32'(got[got.size() - 1]), 32'h66);
    // reset during data bit 3
    q.push_back(8'h81);
    q.push_back(8'h42);
    fifo_empty = 0;
    wait_bit(4 * CPB + 1);
    rst = 1;
    step();
    rst = 0;
    check("t5_tx", 32'(tx), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_cnt", 32'(bytes_sent), 0);
    wait_frames_to(frames + 1);
    check("t5_byte", 32'(got[got.size() - 1]), 32'h42);
    // random bytes with random enable toggling; narrow counter wraps 1,2,3,0,1
    rst = 1;
    step();
    rst = 0;
    p = frames;
    for (int i = 0; i < 5; i++) begin
      rb[i] = 8'($urandom);
      q.push_back(rb[i]);
      fifo_empty = 0;
      repeat ($urandom_range(0, 20)) begin
        tx_enable = 1'($urandom_range(0, 1));
        step();
      end
    end
    tx_enable = 1;
    wait_frames_to(p + 5);
    step();
    for (int i = 0; i < 5; i++) check("t6_byte", 32'(got[p + i]), 32'(rb[i]));
    check("t6_cnt2", 32'(bytes_sent2), 1);
    check("t6_cnt", 32'(bytes_sent), 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
